io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable clk samples before a button level change is accepted (legal range 2..2^20).
REQ-002 Parameter SW_W, default 18, switch input width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_req  input  1  IN instruction in current cycle, from controller MO.
REQ-006 out_req  input  1  OUT instruction in current cycle, from controller out.
REQ-007 out_data  input  32  register value to be shown by OUT.
REQ-008 sw  input  SW_W  user switches, asynchronous to clk.
REQ-009 btn_confirm  input  1  raw user confirm pushbutton, active-high, asynchronous to clk.
REQ-010 flag  output  1  stall request to the controller; the controller holds halt while flag=1 during IN/OUT.
REQ-011 in_data  output  32  zero-extended switch value captured for IN.
REQ-012 display  output  32  value shown to the user.
REQ-013 display_valid  output  1  display holds an OUT value.

Function
REQ-014 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE; held in an enum.
REQ-015 flag = 1 combinationally in IDLE when (in_req | out_req), so the PC does not advance in the first cycle of a request; flag = 1 in WAIT_PRESS and WAIT_RELEASE; flag = 0 in DONE.
REQ-016 IDLE -> WAIT_PRESS on (in_req | out_req); if both are asserted, treat as IN.
REQ-017 On an OUT acceptance edge: display <= out_data, display_valid <= 1.
REQ-018 WAIT_PRESS -> WAIT_RELEASE on the debounced rising edge of btn_confirm; for IN, in_data <= {zeros, synchronized sw} on that same edge.
REQ-019 WAIT_RELEASE -> DONE on the debounced falling edge of btn_confirm.
REQ-020 DONE lasts exactly one cycle (the instruction retires, writeback uses in_data) -> IDLE unconditionally; requests are ignored in DONE.
REQ-021 A back-to-back IN/OUT is seen fresh in IDLE and requires a new press/release.
REQ-022 If a request deasserts in WAIT_* (illegal), the FSM still completes the handshake; flag is unaffected.
REQ-023 btn_confirm and sw each pass through a 2-flop synchronizer; the button is then debounced. Total press latency = 2 + DEBOUNCE_CYCLES + 1 cycles from a stable raw level to the FSM edge.
REQ-024 in_data and display hold their values until overwritten by the next IN or OUT.

Reset
REQ-025 rst_n low forces immediately: state=IDLE, flag=0 (excluding the combinational term of REQ-015), in_data=0, display=0, display_valid=0, synchronizers and debouncer counter=0, debounced level=0.
REQ-026 Reset mid-handshake abandons the transaction; after release, a button still held must first be seen released and then pressed again before it counts.

Configuration
REQ-027 Macro IO_ECHO_EN: when defined, display shows {zeros, synchronized sw} live while the FSM is in WAIT_PRESS/WAIT_RELEASE for an IN, and display_valid=0 during that time; display reverts to the last OUT value (and its display_valid) in DONE. When undefined, display changes only per REQ-017.

Structure
REQ-028 Package io_pkg holds: the state enum io_state_t, DATA_W=32, the default SW_W=18.
REQ-029 Sub-module io_debounce (sync + counter + stable level + rise/fall pulses), instantiated once for btn_confirm.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 OUT: out_req=1, out_data=0x0000_00AB -> flag=1 in the same cycle, display=0xAB and display_valid=1 next edge; press 10 cycles, release 10 cycles -> flag=0 for exactly one cycle, then IDLE.
REQ-031 IN: in_req=1, sw=0x2_5A5A, press -> in_data=0x0002_5A5A latched at the press edge; sw changed to 0 before release -> in_data unchanged.
REQ-032 Bounce: btn toggles every 2 cycles for 20 cycles -> no transition; FSM stays in WAIT_PRESS, flag=1.
REQ-033 Reset during WAIT_RELEASE with button held -> flag=0, display=0; the next IN is not completed until release then press.
REQ-034 in_req and out_req both =1 -> handled as IN, display unchanged (without IO_ECHO_EN); with IO_ECHO_EN, display follows sw live during the wait.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared types and widths for the IN/OUT responder.
// Holds the FSM state enum, data width and default switch width.
package io_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 18;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } io_state_t;

endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: controller <-> responder bundle.
// master = controller (in_req, out_req, out_data out; flag, in_data in).
interface io_responder_if;
  import io_pkg::*;

  logic              in_req;
  logic              out_req;
  logic [DATA_W-1:0] out_data;
  logic              flag;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_req,
    output out_req,
    output out_data,
    input  flag,
    input  in_data
  );

  modport slave (
    input  in_req,
    input  out_req,
    input  out_data,
    output flag,
    output in_data
  );

endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop sync, stable-count filter, rise/fall pulses.
// Ports: clk, rst_n, raw_i (async level), rise_o/fall_o (1-cycle pulses).
module io_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(CYCLES);

  logic          s1_q, s2_q;
  logic [1:0]    vld_q;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A rise only counts once the synchronized input has been
  // seen low after reset, so a button held through reset must
  // be released before its next press is accepted.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    armed_d = armed_q
            | (vld_q[1] & ~s2_q & ~level_q);
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = s2_q;
      rise_d  = s2_q & armed_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      vld_q   <= '0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/io_responder.sv
// io_responder: stalls IN/OUT until a debounced confirm press/release.
// Ports: clk, rst_n, bus (slave), sw, btn_confirm, display, display_valid.
// Option: IO_ECHO_EN echoes live switches on display during an IN wait.
module io_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = io_pkg::SW_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  io_responder_if.slave             bus,
  input  logic [SW_W-1:0]           sw,
  input  logic                      btn_confirm,
  output logic [io_pkg::DATA_W-1:0] display,
  output logic                      display_valid
);
  import io_pkg::*;

  logic [SW_W-1:0]   sw1_q, sw2_q;
  logic              rise, fall;
  logic              req;
  logic              flag_c;
  io_state_t         state_q, state_d;
  logic              is_in_q, is_in_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic              dvalid_q, dvalid_d;

  io_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_confirm),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign req = bus.in_req | bus.out_req;

  always_comb begin
    state_d   = state_q;
    is_in_d   = is_in_q;
    in_data_d = in_data_q;
    disp_d    = disp_q;
    dvalid_d  = dvalid_q;
    flag_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall already in the request cycle.
        flag_c = req;
        if (req) begin
          state_d = WAIT_PRESS;
          is_in_d = bus.in_req;
          if (!bus.in_req) begin
            disp_d   = bus.out_data;
            dvalid_d = 1'b1;
          end
        end
      end
      WAIT_PRESS: begin
        flag_c = 1'b1;
        if (rise) begin
          state_d = WAIT_RELEASE;
          if (is_in_q) in_data_d = DATA_W'(sw2_q);
        end
      end
      WAIT_RELEASE: begin
        flag_c = 1'b1;
        if (fall) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw1_q     <= '0;
      sw2_q     <= '0;
      state_q   <= IDLE;
      is_in_q   <= 1'b0;
      in_data_q <= '0;
      disp_q    <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      sw1_q     <= sw;
      sw2_q     <= sw1_q;
      state_q   <= state_d;
      is_in_q   <= is_in_d;
      in_data_q <= in_data_d;
      disp_q    <= disp_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign bus.flag    = flag_c;
  assign bus.in_data = in_data_q;

`ifdef IO_ECHO_EN
  logic echo;
  assign echo = is_in_q
              & ((state_q == WAIT_PRESS)
              |  (state_q == WAIT_RELEASE));
  assign display       = echo ? DATA_W'(sw2_q) : disp_q;
  assign display_valid = echo ? 1'b0 : dvalid_q;
`else
  assign display       = disp_q;
  assign display_valid = dvalid_q;
`endif

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: vector table, random transactions, reset corner.
// Expected timing is derived from press/release cycle arithmetic.
module tb_io_responder;
  import io_pkg::*;

  localparam int D   = 4;
  localparam int SWW = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SWW-1:0]  sw = '0;
  logic            btn = 1'b0;
  logic [31:0]     display;
  logic            display_valid;

  io_responder_if bus();

  io_responder #(
    .DEBOUNCE_CYCLES (D),
    .SW_W            (SWW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .sw            (sw),
    .btn_confirm   (btn),
    .display       (display),
    .display_valid (display_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_in = '0;
  logic [31:0] exp_disp = '0;
  logic        exp_val = 1'b0;
  logic [SWW-1:0] prev_sw = '0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [SWW-1:0] swv;
    int          pd;
    int          hold;
    bit          bounce;
    bit          drop;
    logic [31:0] e_in;
    logic [31:0] e_disp;
    logic        e_val;
  } vec_t;

  vec_t v [6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic fexp,
                         input logic [31:0] dexp,
                         input logic vexp);
    chk({tag, ".flag"}, 32'(bus.flag), 32'(fexp));
    chk({tag, ".in_data"}, bus.in_data, exp_in);
    chk({tag, ".display"}, display, dexp);
    chk({tag, ".valid"}, 32'(display_valid), 32'(vexp));
  endtask

  // kind: 0 = OUT, 1 = IN, 2 = both (handled as IN).
  // Request driven in cycle 0, accepted at edge 1; press driven
  // in cycle pd is seen at edge pd+D+3, release likewise.
  task automatic txn(input int kind,
                     input logic [31:0] data,
                     input logic [SWW-1:0] swv,
                     input int pd0,
                     input int hold,
                     input bit bounce,
                     input bit drop);
    int pd, rd, pe, de;
    logic [SWW-1:0] sw2;
    logic [31:0] dexp;
    logic vexp;
    pd  = bounce ? pd0 + 22 : pd0;
    rd  = pd + hold;
    pe  = pd + D + 3;
    de  = rd + D + 3;
    sw2 = SWW'($urandom);
    for (int c = 0; c <= de; c++) begin
      step();
      if (c == 0) begin
        bus.in_req   = (kind != 0);
        bus.out_req  = (kind != 1);
        bus.out_data = data;
        sw           = swv;
      end
      if (bounce && c >= 1 && c <= 20)
        btn = ((((c - 1) / 2) % 2) == 0);
      if (c == pd) btn = 1'b1;
      if (c == rd) btn = 1'b0;
      if (drop && c == 2) begin
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
      end
      if (kind != 0 && c == pe + 1) sw = sw2;
      if (kind == 0 && c == 1) begin
        exp_disp = data;
        exp_val  = 1'b1;
      end
      if (kind != 0 && c == pe) exp_in = 32'(swv);
      dexp = exp_disp;
      vexp = exp_val;
`ifdef IO_ECHO_EN
      if (kind != 0 && c >= 1 && c < de) begin
        vexp = 1'b0;
        dexp = 32'(c < 2 ? prev_sw
                 : (c < pe + 3 ? swv : sw2));
      end
`endif
      @(negedge clk);
      chk_all("txn", (c < de), dexp, vexp);
    end
    prev_sw = (kind != 0) ? sw2 : swv;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bus.in_req   = 1'b0;
    bus.out_req  = 1'b0;
    bus.out_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_all("rst", 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    repeat (D + 5) step();
    @(negedge clk);
    chk_all("post_rst", 1'b0, 32'h0, 1'b0);

    v[0] = '{0, 32'hAB, 18'h0, 2, 10, 0, 0,
             32'h0, 32'hAB, 1'b1};
    v[1] = '{1, 32'h0, 18'h25A5A, 2, 10, 0, 0,
             32'h25A5A, 32'hAB, 1'b1};
    v[2] = '{2, 32'h1234, 18'h3FFFF, 1, 11, 0, 0,
             32'h3FFFF, 32'hAB, 1'b1};
    v[3] = '{1, 32'h0, 18'h00001, 2, 10, 1, 0,
             32'h1, 32'hAB, 1'b1};
    v[4] = '{0, 32'hFFFF_FFFF, 18'h0, 3, 12, 0, 1,
             32'h1, 32'hFFFF_FFFF, 1'b1};
    v[5] = '{1, 32'h0, 18'h0, 1, 10, 0, 1,
             32'h0, 32'hFFFF_FFFF, 1'b1};

    for (int i = 0; i < 6; i++) begin
      txn(v[i].kind, v[i].data, v[i].swv, v[i].pd,
          v[i].hold, v[i].bounce, v[i].drop);
      chk("vec.in_data", bus.in_data, v[i].e_in);
      chk("vec.display", display, v[i].e_disp);
      chk("vec.valid", 32'(display_valid),
          32'(v[i].e_val));
    end

    step();
    bus.in_req  = 1'b0;
    bus.out_req = 1'b0;
    @(negedge clk);
    chk_all("idle", 1'b0, exp_disp, exp_val);

    for (int i = 0; i < 16; i++) begin
      txn($urandom_range(0, 2), $urandom,
          SWW'($urandom), $urandom_range(1, 5),
          $urandom_range(D + 6, D + 12),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0));
    end

    // Reset while the button is held in WAIT_RELEASE.
    step();
    bus.in_req  = 1'b1;
    bus.out_req = 1'b0;
    sw = 18'h30155;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) btn = 1'b1;
    end
    @(negedge clk);
    chk("rst_mid.in_data", bus.in_data, 32'h30155);
    #1;
    rst_n = 1'b0;
    bus.in_req = 1'b0;
    #1;
    exp_in   = '0;
    exp_disp = '0;
    exp_val  = 1'b0;
    chk_all("rst_mid", 1'b0, 32'h0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.in_req = 1'b1;
    sw = 18'h00077;
    prev_sw = sw;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      chk("held.flag", 32'(bus.flag), 32'h1);
      chk("held.in_data", bus.in_data, 32'h0);
    end
    btn = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk);
      chk("rel.flag", 32'(bus.flag), 32'h1);
      chk("rel.in_data", bus.in_data, 32'h0);
    end
    step();
    btn = 1'b1;
    for (int c = 1; c <= D + 3; c++) begin
      step();
      @(negedge clk);
      chk("repress.in_data", bus.in_data,
          (c >= D + 3) ? 32'h77 : 32'h0);
    end
    step();
    btn = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      if (!bus.flag) begin
        found = 1'b1;
        break;
      end
    end
    chk("repress.done", 32'(found), 32'h1);
    step();
    bus.in_req = 1'b0;
    @(negedge clk);
    chk("final.flag", 32'(bus.flag), 32'h0);
    chk("final.in_data", bus.in_data, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
